facto_engine: RTL

FACTO_ENGINE -- requirements
Module: facto_engine

---
 rtl/facto_pkg.sv | 15 +
 rtl/facto_mul.sv | 59 +++++
 rtl/facto_engine.sv | 128 ++++++++++++
 3 files changed

// File: rtl/facto_pkg.sv
// Shared types and default sizing for the factorial engine and its multiplier.
package facto_pkg;

    localparam int DATA_W     = 64;
    localparam int MUL_CYCLES = 64;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_MUL,
        S_DONE
    } state_t;

endpackage

// File: rtl/facto_mul.sv
// Radix-2 shift-add multiplier: 2*DATA_W-bit multiplicand times DATA_W-bit multiplier,
// low 2*DATA_W bits kept, one multiplier bit per cycle, abortable.
module facto_mul #(
    parameter int DATA_W     = 64,
    parameter int MUL_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [2*DATA_W-1:0]   mcand_i,
    input  logic [DATA_W-1:0]     mplier_i,
    output logic                  done_o,
    output logic [2*DATA_W-1:0]   product_o
);

    localparam int CNT_W = $clog2(MUL_CYCLES + 1);

    logic [2*DATA_W-1:0] mcand_q;
    logic [DATA_W-1:0]   mplier_q;
    logic [2*DATA_W-1:0] acc_q;
    logic [2*DATA_W-1:0] acc_d;
    logic [CNT_W-1:0]    cnt_q;
    logic                run_q;

    // Product of the current step is exposed combinationally so the final
    // step's sum is captured by the engine on the same edge that retires it.
    always_comb begin
        acc_d     = acc_q + (mplier_q[0] ? mcand_q : '0);
        product_o = acc_d;
        done_o    = run_q && (cnt_q == '0);
    end

    always_ff @(posedge clk) begin
        if (reset || abort_i) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
        end else if (start_i) begin
            mcand_q  <= mcand_i;
            mplier_q <= mplier_i;
            acc_q    <= '0;
            cnt_q    <= CNT_W'(MUL_CYCLES - 1);
            run_q    <= 1'b1;
        end else if (run_q) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            if (cnt_q == '0) begin
                run_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/facto_engine.sv
// Iterative factorial engine: acc = N! mod 2^(2*DATA_W) via repeated shift-add multiplies.
//   state   | meaning
//   S_IDLE  | waiting for an op_start rising edge
//   S_LOAD  | acc=1, n=operand
//   S_CHECK | n>1 launches a multiply step, else finish
//   S_MUL   | multiplier running acc*n
//   S_DONE  | result held, op_done=1, new start allowed
module facto_engine
    import facto_pkg::*;
#(
    parameter int DATA_W     = facto_pkg::DATA_W,
    parameter int MUL_CYCLES = facto_pkg::MUL_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              op_start,
    input  logic              op_clear,
    input  logic              intr_en,
    input  logic [DATA_W-1:0] operand,
    output logic [DATA_W-1:0] result_h,
    output logic [DATA_W-1:0] result_l,
    output logic              op_done,
    output logic              busy,
    output logic              interrupt
);

    state_t              state_q;
    logic [2*DATA_W-1:0] acc_q;
    logic [DATA_W-1:0]   n_q;
    logic [DATA_W-1:0]   result_h_q;
    logic [DATA_W-1:0]   result_l_q;
    logic                op_done_q;
    logic                busy_q;
    logic                op_start_prev_q;

    logic                start_edge;
    logic                mul_start;
    logic                mul_done;
    logic [2*DATA_W-1:0] mul_product;

    assign start_edge = op_start && !op_start_prev_q;
    assign mul_start  = (state_q == S_CHECK) && (n_q > DATA_W'(1)) && !op_clear;

    facto_mul #(
        .DATA_W     (DATA_W),
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mul (
        .clk       (clk),
        .reset     (reset),
        .start_i   (mul_start),
        .abort_i   (op_clear),
        .mcand_i   (acc_q),
        .mplier_i  (n_q),
        .done_o    (mul_done),
        .product_o (mul_product)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            acc_q           <= '0;
            n_q             <= '0;
            result_h_q      <= '0;
            result_l_q      <= '0;
            op_done_q       <= 1'b0;
            busy_q          <= 1'b0;
            op_start_prev_q <= 1'b0;
        end else begin
            op_start_prev_q <= op_start;
            // Clear wins over a coincident start edge; that edge is consumed here.
            if (op_clear) begin
                state_q    <= S_IDLE;
                acc_q      <= '0;
                n_q        <= '0;
                result_h_q <= '0;
                result_l_q <= '0;
                op_done_q  <= 1'b0;
                busy_q     <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE, S_DONE: begin
                        if (start_edge) begin
                            state_q    <= S_LOAD;
                            busy_q     <= 1'b1;
                            result_h_q <= '0;
                            result_l_q <= '0;
                            op_done_q  <= 1'b0;
                        end
                    end
                    S_LOAD: begin
                        acc_q   <= (2*DATA_W)'(1);
                        n_q     <= operand;
                        state_q <= S_CHECK;
                    end
                    S_CHECK: begin
                        if (n_q > DATA_W'(1)) begin
                            state_q <= S_MUL;
                        end else begin
                            state_q    <= S_DONE;
                            busy_q     <= 1'b0;
                            result_h_q <= acc_q[2*DATA_W-1:DATA_W];
                            result_l_q <= acc_q[DATA_W-1:0];
                            op_done_q  <= 1'b1;
                        end
                    end
                    S_MUL: begin
                        if (mul_done) begin
                            acc_q   <= mul_product;
                            n_q     <= n_q - DATA_W'(1);
                            state_q <= S_CHECK;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign result_h  = result_h_q;
    assign result_l  = result_l_q;
    assign op_done   = op_done_q;
    assign busy      = busy_q;
    assign interrupt = op_done_q & intr_en;

endmodule
